fpdiv_result_buffer: RTL

- Downstream stage of the FP32 divider (`fpdiv`).
- Watches the divider's `DONE` level and captures `AbyB` and `EXCEPTION` once per completed division.
- Classifies each captured quotient as normal, zero, infinity, NaN or subnormal.
- Queues captured entries in a small FIFO and presents them to the consumer over a valid/ready handshake; a sticky flag records lost results.

---
 rtl/fpdiv_result_buffer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fpdiv_result_buffer.sv
// fpdiv_result_buffer
//
// Downstream stage of the FP32 divider. Captures the divider quotient and exception code once
// per rising edge of the divider DONE level, classifies the quotient, and queues the entry in a
// small circular FIFO that is drained over a valid/ready handshake. A sticky flag records
// captures that were dropped because the FIFO was full and nothing was popped that cycle.
//
// Optional feature macro: FPDIV_RESULT_STATS_EN
//   When defined, adds four 16-bit saturating counters (total/NaN/inf/zero accepted captures)
//   and the STAT_* output ports. When undefined, those counters and ports are absent.
//
// Parameters:
//   DEPTH         FIFO entries, power of two, >= 2
// Ports:
//   CLOCK         sole clock, rising edge
//   RESET         asynchronous, active-high
//   DONE_IN       divider DONE level
//   QUOT_IN       divider quotient (AbyB)
//   EXC_IN        divider exception code
//   CLEAR         synchronous clear of OVERFLOW and stats counters (FIFO untouched)
//   RESULT_VALID  head entry available
//   RESULT_READY  consumer accepts head entry
//   RESULT_DATA   head quotient
//   RESULT_EXC    head exception code
//   RESULT_CLASS  head class: 0 normal, 1 zero, 2 inf, 3 NaN, 4 subnormal
//   COUNT         occupied entries
//   FULL          COUNT == DEPTH
//   OVERFLOW      sticky, a capture was dropped
//   STAT_*        saturating counters (only with FPDIV_RESULT_STATS_EN)

module fpdiv_result_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic                      DONE_IN,
  input  logic [31:0]               QUOT_IN,
  input  logic [1:0]                EXC_IN,
  input  logic                      CLEAR,
  output logic                      RESULT_VALID,
  input  logic                      RESULT_READY,
  output logic [31:0]               RESULT_DATA,
  output logic [1:0]                RESULT_EXC,
  output logic [2:0]                RESULT_CLASS,
  output logic [$clog2(DEPTH):0]    COUNT,
  output logic                      FULL,
  output logic                      OVERFLOW
`ifdef FPDIV_RESULT_STATS_EN
  ,
  output logic [15:0]               STAT_NAN,
  output logic [15:0]               STAT_INF,
  output logic [15:0]               STAT_ZERO,
  output logic [15:0]               STAT_TOTAL
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthCnt = DEPTH[PtrW:0];

  localparam logic [2:0] ClsNormal = 3'd0;
  localparam logic [2:0] ClsZero   = 3'd1;
  localparam logic [2:0] ClsInf    = 3'd2;
  localparam logic [2:0] ClsNan    = 3'd3;
  localparam logic [2:0] ClsSub    = 3'd4;

  function automatic logic [2:0] classify(input logic [31:0] q);
    logic [7:0]  exp_f;
    logic [22:0] man_f;
    exp_f = q[30:23];
    man_f = q[22:0];
    if (exp_f == 8'hFF) begin
      classify = (man_f != '0) ? ClsNan : ClsInf;
    end else if (exp_f == 8'h00) begin
      classify = (man_f != '0) ? ClsSub : ClsZero;
    end else begin
      classify = ClsNormal;
    end
  endfunction

  logic            done_q;
  logic [31:0]     data_q [DEPTH];
  logic [1:0]      exc_q  [DEPTH];
  logic [2:0]      cls_q  [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            overflow_q;

  logic capture, pop, push, drop, full, valid;

  assign valid   = (count_q != '0);
  assign full    = (count_q == DepthCnt);
  assign capture = DONE_IN && !done_q;
  assign pop     = valid && RESULT_READY;
  // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q  <= DONE_IN;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      // A drop in the same cycle as CLEAR wins so the loss is not hidden.
      overflow_q <= (overflow_q && !CLEAR) || drop;
    end
  end

  // Storage is reset so the head fields read zero straight out of reset.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        exc_q[i]  <= '0;
        cls_q[i]  <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= QUOT_IN;
      exc_q[wr_ptr_q]  <= EXC_IN;
      cls_q[wr_ptr_q]  <= classify(QUOT_IN);
    end
  end

  assign RESULT_VALID = valid;
  assign RESULT_DATA  = data_q[rd_ptr_q];
  assign RESULT_EXC   = exc_q[rd_ptr_q];
  assign RESULT_CLASS = cls_q[rd_ptr_q];
  assign COUNT        = count_q;
  assign FULL         = full;
  assign OVERFLOW     = overflow_q;

`ifdef FPDIV_RESULT_STATS_EN
  logic [15:0] stat_nan_q, stat_inf_q, stat_zero_q, stat_total_q;
  logic [2:0]  cap_cls;

  assign cap_cls = classify(QUOT_IN);

  // CLEAR zeroes first; an accepted capture in the same cycle is still counted.
  function automatic logic [15:0] sat_next(input logic [15:0] cur, input logic clr,
                                           input logic inc);
    logic [15:0] base;
    base = clr ? 16'h0000 : cur;
    sat_next = (inc && base != 16'hFFFF) ? base + 16'd1 : base;
  endfunction

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      stat_nan_q   <= '0;
      stat_inf_q   <= '0;
      stat_zero_q  <= '0;
      stat_total_q <= '0;
    end else begin
      stat_total_q <= sat_next(stat_total_q, CLEAR, push);
      stat_nan_q   <= sat_next(stat_nan_q,   CLEAR, push && cap_cls == ClsNan);
      stat_inf_q   <= sat_next(stat_inf_q,   CLEAR, push && cap_cls == ClsInf);
      stat_zero_q  <= sat_next(stat_zero_q,  CLEAR, push && cap_cls == ClsZero);
    end
  end

  assign STAT_NAN   = stat_nan_q;
  assign STAT_INF   = stat_inf_q;
  assign STAT_ZERO  = stat_zero_q;
  assign STAT_TOTAL = stat_total_q;
`endif

endmodule
